fp_norm_arbiter: RTL and testbench

FP_NORM_ARBITER -- requirements
Module: fp_norm_arbiter

---
 rtl/fp_norm_arbiter.sv | 78 +++++++
 tb/tb_fp_norm_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_arbiter.sv
// rtl/fp_norm_arbiter.sv - two-requester round-robin arbiter feeding the shared FP prenormalize/shift stage
// Alternating grant on contention, single registered output slot, saturating stall counter.
module fp_norm_arbiter #(
  parameter  int EXPO_W    = 11,
  parameter  int SHIFT_W   = 11,
  parameter  int ID_W      = 3,
  localparam int PAYLOAD_W = 5 + EXPO_W + 2 * SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [PAYLOAD_W-1:0] req0_data,
  input  logic [ID_W-1:0]      req0_id,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [PAYLOAD_W-1:0] req1_data,
  input  logic [ID_W-1:0]      req1_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_src,
  output logic [7:0]           stall_cnt
);

  logic last_grant;
  logic accept;
  logic gnt_valid;
  logic gnt_idx;
  logic xfer;

  // On contention the requester not granted last time wins; no lock between cycles.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_idx = ~last_grant;
    end else if (req1_valid) begin
      gnt_idx = 1'b1;
    end
  end

  // rst gates accept so neither requester sees ready while held in reset.
  assign accept     = ~rst & ~flush & (~out_valid | out_ready);
  assign xfer       = accept & gnt_valid;
  assign req0_ready = xfer & ~gnt_idx;
  assign req1_ready = xfer & gnt_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      stall_cnt  <= 8'd0;
    end else begin
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= gnt_idx ? req1_data : req0_data;
        out_id     <= gnt_idx ? req1_id : req0_id;
        out_src    <= gnt_idx;
        last_grant <= gnt_idx;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && !out_ready) begin
        stall_cnt <= (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
      end else begin
        stall_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// tb/tb_fp_norm_arbiter.sv - scoreboard bench for fp_norm_arbiter
module tb_fp_norm_arbiter;

  localparam int PW   = 38;
  localparam int ID_W = 3;

  typedef struct packed {
    logic            src;
    logic [ID_W-1:0] id;
    logic [PW-1:0]   data;
  } item_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [PW-1:0]   req0_data = '0, req1_data = '0;
  logic [ID_W-1:0] req0_id = '0, req1_id = '0;
  logic            out_valid, out_src;
  logic            out_ready = 1'b0;
  logic [PW-1:0]   out_data;
  logic [ID_W-1:0] out_id;
  logic [7:0]      stall_cnt;

  fp_norm_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_id(req0_id),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_id(req1_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_src(out_src), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_fail = 0;
  item_t sb[$];
  logic  m_last, m_ov;
  int    m_stall;
  item_t m_out;

  function automatic logic [PW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  task automatic model_reset();
    m_last  = 1'b1;
    m_ov    = 1'b0;
    m_stall = 0;
    m_out   = '0;
    sb.delete();
  endtask

  // One clock: drive, check readies against the model, push expected load, clock, pop and check outputs.
  task automatic cycle(input logic v0, input logic v1, input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                       input logic [ID_W-1:0] i0, input logic [ID_W-1:0] i1, input logic ordy, input logic fl);
    logic acc, gv, gi, e0, e1, ld;
    item_t it;
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    req0_id = i0; req1_id = i1; out_ready = ordy; flush = fl;
    #1;
    acc = !fl && (!m_ov || ordy);
    gv  = v0 || v1;
    gi  = (v0 && v1) ? !m_last : v1;
    e0  = acc && gv && !gi;
    e1  = acc && gv && gi;
    ld  = acc && gv;
    n_cmp++;
    if (req0_ready !== e0) begin n_fail++; $display("FAIL req0_ready got=%b exp=%b t=%0t", req0_ready, e0, $time); end
    n_cmp++;
    if (req1_ready !== e1) begin n_fail++; $display("FAIL req1_ready got=%b exp=%b t=%0t", req1_ready, e1, $time); end
    if (ld) sb.push_back(gi ? item_t'({1'b1, i1, d1}) : item_t'({1'b0, i0, d0}));
    m_stall = (m_ov && !ordy) ? ((m_stall == 255) ? 255 : m_stall + 1) : 0;
    if (ld) begin m_ov = 1'b1; m_last = gi; end
    else if (fl || ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
    if (ld) begin
      n_cmp++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL scoreboard_empty t=%0t", $time); end
      else m_out = sb.pop_front();
    end
    it = {out_src, out_id, out_data};
    n_cmp++;
    if (out_valid !== m_ov) begin n_fail++; $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, m_ov, $time); end
    n_cmp++;
    if (it !== m_out) begin n_fail++; $display("FAIL out_payload got=%h exp=%h t=%0t", it, m_out, $time); end
    n_cmp++;
    if (stall_cnt !== 8'(m_stall)) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d t=%0t", stall_cnt, m_stall, $time); end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    req0_data = rnd(); req1_data = rnd();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    n_cmp++;
    if ({out_valid, out_src, out_id, out_data} !== '0) begin n_fail++; $display("FAIL reset_out got=%b/%b/%h/%h exp=0", out_valid, out_src, out_id, out_data); end
    n_cmp++;
    if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_transfer();
    cycle(1'b1, 1'b0, 38'h12_3456_78A5, '0, 3'd2, 3'd0, 1'b1, 1'b0);
    n_cmp++;
    if (out_data[7:0] !== 8'hA5 || out_id !== 3'd2 || out_src !== 1'b0) begin
      n_fail++; $display("FAIL first_xfer got=%h/%0d/%b exp=a5/2/0", out_data[7:0], out_id, out_src);
    end
    idle(2, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, rnd(), rnd(), 3'(k), 3'(7 - k), 1'b1, 1'b0);
    idle(1, 1'b1);
  endtask

  task automatic test_single_and_drop();
    cycle(1'b0, 1'b1, rnd(), rnd(), 3'd1, 3'd5, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, rnd(), rnd(), 3'd1, 3'd6, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, rnd(), rnd(), 3'd3, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, rnd(), rnd(), 3'd4, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, rnd(), rnd(), 3'd0, 3'd2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 1'b0);
    idle(1, 1'b1);
  endtask

  task automatic test_stall_saturate();
    cycle(1'b1, 1'b0, rnd(), '0, 3'd6, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) cycle(1'b1, 1'b1, rnd(), rnd(), 3'd1, 3'd2, 1'b0, 1'b0);
    n_cmp++;
    if (stall_cnt !== 8'd255) begin n_fail++; $display("FAIL stall_saturate got=%0d exp=255", stall_cnt); end
    cycle(1'b0, 1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 1'b0);
    n_cmp++;
    if (stall_cnt !== 8'd0) begin n_fail++; $display("FAIL stall_clear got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 1'b0, rnd(), '0, 3'd3, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, '0, rnd(), 3'd0, 3'd4, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, '0, rnd(), 3'd0, 3'd5, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, rnd(), rnd(), 3'd1, 3'd1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, rnd(), rnd(), 3'd2, 3'd2, 1'b1, 1'b0);
    idle(1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd(), rnd(), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    idle(1, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, '0, rnd(), 3'd0, 3'd7, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, rnd(), rnd(), 3'd1, 3'd2, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
    n_cmp++;
    if ({req0_ready, req1_ready, stall_cnt} !== 10'd0) begin n_fail++; $display("FAIL async_reset_misc got=%b%b/%0d exp=00/0", req0_ready, req1_ready, stall_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1, rnd(), rnd(), 3'd4, 3'd5, 1'b1, 1'b0);
    n_cmp++;
    if (out_src !== 1'b0) begin n_fail++; $display("FAIL post_reset_grant got=%b exp=0", out_src); end
    idle(1, 1'b1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_transfer();
    test_back_to_back();
    test_single_and_drop();
    test_stall_saturate();
    test_flush();
    test_random();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
